// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants and helpers for the display receive path and its driver bench.
// Segment bit order: bit0 = a ... bit6 = g, 1 = lit.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_ERR = 4'hF;

endpackage

// File: rtl/seven_seg_encoder.sv
// Converts a 7-bit segment pattern back to BCD; unknown patterns give BCD_ERR,
// all-off gives blank with BCD 0.
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    bcd   = BCD_ERR;
    legal = 1'b0;
    blank = 1'b0;
    case (seg)
      SEG_0:     begin bcd = 4'd0; legal = 1'b1; end
      SEG_1:     begin bcd = 4'd1; legal = 1'b1; end
      SEG_2:     begin bcd = 4'd2; legal = 1'b1; end
      SEG_3:     begin bcd = 4'd3; legal = 1'b1; end
      SEG_4:     begin bcd = 4'd4; legal = 1'b1; end
      SEG_5:     begin bcd = 4'd5; legal = 1'b1; end
      SEG_6:     begin bcd = 4'd6; legal = 1'b1; end
      SEG_7:     begin bcd = 4'd7; legal = 1'b1; end
      SEG_8:     begin bcd = 4'd8; legal = 1'b1; end
      SEG_9:     begin bcd = 4'd9; legal = 1'b1; end
      SEG_BLANK: begin bcd = 4'd0; blank = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Receive side of a multiplexed seven-segment bus: synchronises the pins, debounces each
// digit's pattern over STABLE_CNT qualifying samples, then commits the decoded BCD/status.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [6:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   dig_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic [NUM_DIGITS-1:0]   blank_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    upd_o,
  output logic                    coll_o
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]            seg_meta, seg_sync;
  logic [NUM_DIGITS-1:0] dig_meta, dig_sync;

  logic [6:0]    last [NUM_DIGITS];
  logic [CW-1:0] cnt  [NUM_DIGITS];

  logic          single, multi, same, reach;
  logic [IW-1:0] sel_idx;

  logic          pend;
  logic [IW-1:0] pend_idx;

  logic [3:0] dec_bcd;
  logic       dec_legal, dec_blank, dec_err;

  always_comb begin
    multi  = (dig_sync & (dig_sync - NUM_DIGITS'(1))) != '0;
    single = (dig_sync != '0) && !multi;
    sel_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_sync[k]) sel_idx = IW'(k);
    end
    same = (seg_sync == last[sel_idx]);
    // A changed pattern restarts at 1, which is already the commit point when STABLE_CNT is 1.
    reach = same ? (cnt[sel_idx] == CNT_MAX - CNT_ONE) : (STABLE_CNT == 1);
  end

  seven_seg_encoder u_encoder (
    .seg   (last[pend_idx]),
    .bcd   (dec_bcd),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  assign dec_err = !dec_legal && !dec_blank;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      seg_meta <= '0;
      seg_sync <= '0;
      dig_meta <= '0;
      dig_sync <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        last[k] <= '0;
        cnt[k]  <= '0;
      end
      pend     <= 1'b0;
      pend_idx <= '0;
      bcd_o    <= '0;
      valid_o  <= '0;
      blank_o  <= '0;
      err_o    <= '0;
      upd_o    <= 1'b0;
      coll_o   <= 1'b0;
    end else begin
      seg_meta <= seg_i;
      seg_sync <= seg_meta;
      dig_meta <= dig_i;
      dig_sync <= dig_meta;
      coll_o   <= multi;

      pend <= 1'b0;
      if (single) begin
        if (same) begin
          if (cnt[sel_idx] != CNT_MAX) cnt[sel_idx] <= cnt[sel_idx] + CNT_ONE;
        end else begin
          last[sel_idx] <= seg_sync;
          cnt[sel_idx]  <= CNT_ONE;
        end
        pend     <= reach;
        pend_idx <= sel_idx;
      end

      // The encoder reads last[] before any same-edge update, so a commit always
      // reflects the pattern that completed the stable run.
      upd_o <= 1'b0;
      if (pend) begin
        bcd_o[4*pend_idx +: 4] <= dec_bcd;
        valid_o[pend_idx]      <= dec_legal;
        blank_o[pend_idx]      <= dec_blank;
        err_o[pend_idx]        <= dec_err;
        upd_o <= {dec_bcd, dec_legal, dec_blank, dec_err} !=
                 {bcd_o[4*pend_idx +: 4], valid_o[pend_idx], blank_o[pend_idx], err_o[pend_idx]};
      end
    end
  end

endmodule
